// File: rtl/layered_palette_colorizer.sv
// Final pixel stage: priority sprite-layer merge over a direct-colour world
// pixel through a runtime-writable palette, brightness fade and blanking.
// Palette writes are either applied immediately or staged in a shadow
// palette and committed on the vblank rising edge.
module layered_palette_colorizer #(
  parameter int LAYERS           = 4,
  parameter int IDX_W            = 4,
  parameter int CH_W             = 4,
  parameter int TRANSPARENT_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    video_on,
  input  logic                    vblank,
  input  logic [3*CH_W-1:0]       world_pixel,
  input  logic [LAYERS*IDX_W-1:0] layer_idx,
  input  logic [LAYERS-1:0]       layer_active,
  input  logic [CH_W-1:0]         brightness,
  input  logic                    pal_commit_mode,
  input  logic                    pal_wr_en,
  input  logic [IDX_W-1:0]        pal_wr_addr,
  input  logic [3*CH_W-1:0]       pal_wr_data,
  output logic                    pal_wr_ready,
  output logic                    pal_pending,
  output logic [CH_W-1:0]         r,
  output logic [CH_W-1:0]         g,
  output logic [CH_W-1:0]         b
);

  localparam int NUM   = 1 << IDX_W;
  localparam int COL_W = 3 * CH_W;
  localparam int PW    = 2 * CH_W + 1;

  logic             vblank_q, vblank_d;
  logic [COL_W-1:0] live_q   [NUM];
  logic [COL_W-1:0] live_d   [NUM];
  logic [COL_W-1:0] shadow_q [NUM];
  logic [COL_W-1:0] shadow_d [NUM];
  logic [NUM-1:0]   dirty_q, dirty_d;

  logic [COL_W-1:0] sel_q, sel_d;
  logic             vid_q, vid_d;
  logic [CH_W-1:0]  bri_q, bri_d;
  logic [COL_W-1:0] rgb_q, rgb_d;

  logic             commit_cycle;
  logic             wr_acc;
  logic             found;

  // Writes are refused on the commit cycle so shadow->live copy never races a new write.
  assign commit_cycle = vblank && !vblank_q;
  assign pal_wr_ready = !reset && !commit_cycle;
  assign wr_acc       = pal_wr_en && pal_wr_ready;
  assign pal_pending  = |dirty_q;

  function automatic logic [CH_W-1:0] fade(input logic [CH_W-1:0] c,
                                           input logic [CH_W-1:0] bri);
    logic [PW-1:0] p;
    p = PW'(c) * (PW'(bri) + PW'(1));
    return CH_W'(p >> CH_W);
  endfunction

  // Palette next-state: commit of dirty entries, or an accepted write.
  always_comb begin
    vblank_d = vblank;
    live_d   = live_q;
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    if (commit_cycle) begin
      for (int i = 0; i < NUM; i++) begin
        if (dirty_q[i]) live_d[i] = shadow_q[i];
      end
      dirty_d = '0;
    end
    if (wr_acc) begin
      if (pal_commit_mode) begin
        shadow_d[pal_wr_addr] = pal_wr_data;
        dirty_d[pal_wr_addr]  = 1'b1;
      end else begin
        live_d[pal_wr_addr] = pal_wr_data;
      end
    end
  end

  // Stage 1 select: lowest-numbered visible layer wins, else the world pixel.
  // Lookups read live_q, so a same-cycle palette write returns the old colour.
  always_comb begin
    found = 1'b0;
    sel_d = world_pixel;
    for (int n = 0; n < LAYERS; n++) begin
      if (!found && layer_active[n] &&
          ((TRANSPARENT_ZERO == 0) || (layer_idx[n*IDX_W +: IDX_W] != '0))) begin
        found = 1'b1;
        sel_d = live_q[layer_idx[n*IDX_W +: IDX_W]];
      end
    end
    vid_d = video_on;
    bri_d = brightness;
  end

  // Stage 2: fade each channel with the brightness captured alongside the pixel, then blank.
  always_comb begin
    rgb_d = '0;
    if (vid_q) begin
      rgb_d = {fade(sel_q[COL_W-1 -: CH_W], bri_q),
               fade(sel_q[2*CH_W-1 -: CH_W], bri_q),
               fade(sel_q[CH_W-1:0], bri_q)};
    end
  end

  // State registers; vblank_q resets high so a vblank already asserted at release does not commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b1;
      live_q   <= '{default: '0};
      shadow_q <= '{default: '0};
      dirty_q  <= '0;
      sel_q    <= '0;
      vid_q    <= 1'b0;
      bri_q    <= '0;
      rgb_q    <= '0;
    end else begin
      vblank_q <= vblank_d;
      live_q   <= live_d;
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
      sel_q    <= sel_d;
      vid_q    <= vid_d;
      bri_q    <= bri_d;
      rgb_q    <= rgb_d;
    end
  end

  assign r = rgb_q[COL_W-1 -: CH_W];
  assign g = rgb_q[2*CH_W-1 -: CH_W];
  assign b = rgb_q[CH_W-1:0];

endmodule
